// File: rtl/flow_pkg.sv
// Shared types and defaults for the flow deserializer and its overflow counter.
package flow_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  // Bits needed to count 0..w-1 received bits, never narrower than 1.
  function automatic int bit_cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ovf_counter.sv
// Rising-edge detector on the comparator overflow level feeding a saturating event counter.
module ovf_counter
  import flow_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             clr,
  input  logic             ovf_in,
  output logic [CNT_W-1:0] ovf_count,
  output logic             ovf_sat
);

  logic             r_ovf_d;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;
  logic             w_sat;

  assign w_rise = ovf_in & ~r_ovf_d;
  assign w_sat  = &r_count;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_ovf_d <= 1'b0;
      r_count <= '0;
    end else begin
      r_ovf_d <= ovf_in;
      if (clr) begin
        r_count <= '0;
      end else if (w_rise && !w_sat) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign ovf_count = r_count;
  assign ovf_sat   = w_sat;

endmodule

// File: rtl/flow_deser.sv
// Serial-to-parallel word assembler with a one-deep valid/ready output stage and overflow event tracking.
module flow_deser
  import flow_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             ovf_in,
  input  logic             clr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] ovf_count,
  output logic             ovf_sat,
  output logic             drop
);

  localparam int              BC_W     = bit_cnt_width(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [BC_W-1:0]  w_bit_cnt_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_drop;
  logic             w_complete;
  logic             w_load;
  logic             w_consume;

  // Incoming bit lands at the position given by the bit counter, so bit 0 is the first one received.
  always_comb begin
    w_word            = r_shift;
    w_word[r_bit_cnt] = bit_in;
  end

  assign w_complete = bit_en & ~clr & (r_bit_cnt == LAST_BIT);
  assign w_consume  = r_valid & out_ready;
  assign w_load     = w_complete & (~r_valid | out_ready);

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    if (clr) begin
      w_state_next   = IDLE;
      w_bit_cnt_next = '0;
      w_shift_next   = '0;
    end else if (bit_en) begin
      case (r_state)
        IDLE: begin
          w_state_next   = SHIFT;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          w_shift_next   = w_word;
        end
        SHIFT: begin
          if (w_complete) begin
            w_state_next   = IDLE;
            w_bit_cnt_next = '0;
            w_shift_next   = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_shift_next   = w_word;
          end
        end
        default: begin
          w_state_next   = IDLE;
          w_bit_cnt_next = '0;
          w_shift_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
    end
  end

  // A completed word is lost only when the holding register is full and not draining this cycle.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      if (clr) begin
        r_drop <= 1'b0;
      end else if (w_complete && r_valid && !out_ready) begin
        r_drop <= 1'b1;
      end
    end
  end

  ovf_counter #(
    .CNT_W(CNT_W)
  ) u_ovf_counter (
    .clock     (clock),
    .resetb    (resetb),
    .clr       (clr),
    .ovf_in    (ovf_in),
    .ovf_count (ovf_count),
    .ovf_sat   (ovf_sat)
  );

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign drop       = r_drop;

endmodule
